// File: rtl/ram_fifo_ctrl.sv
// FIFO controller for an external 32x4 dual-port RAM with registered read data.
// Owns pointers, occupancy and flags; all data storage lives in the RAM.
module ram_fifo_ctrl #(
  parameter int unsigned AF_LEVEL = 28,
  parameter int unsigned AE_LEVEL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       push,
  input  logic [3:0] push_data,
  input  logic       pop,
  output logic [3:0] pop_data,
  output logic       pop_valid,
  output logic       full,
  output logic       empty,
  output logic       almost_full,
  output logic       almost_empty,
  output logic [5:0] count,
  output logic       overflow,
  output logic       underflow,
  output logic       ram_we,
  output logic [4:0] ram_a,
  output logic [3:0] ram_di,
  output logic [4:0] ram_dpra,
  input  logic [3:0] ram_dpo
);

  localparam logic [5:0] DEPTH  = 6'd32;
  localparam logic [5:0] AF_LVL = 6'(AF_LEVEL);
  localparam logic [5:0] AE_LVL = 6'(AE_LEVEL);

  logic [4:0] wr_ptr_q, wr_ptr_d;
  logic [4:0] rd_ptr_q, rd_ptr_d;
  logic [5:0] count_q, count_d;
  logic       empty_q, empty_d;
  logic       full_q, full_d;
  logic       almost_empty_q, almost_empty_d;
  logic       almost_full_q, almost_full_d;
  logic       pop_valid_q, pop_valid_d;
  logic       overflow_q, overflow_d;
  logic       underflow_q, underflow_d;
  logic       push_acc, pop_acc;

  always_comb begin
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a paired push.
    pop_acc  = pop & rst_n & ~clr & ~empty_q;
    push_acc = push & rst_n & ~clr & (~full_q | pop_acc);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pop_valid_d = pop_acc;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (clr) begin
      wr_ptr_d = 5'd0;
      rd_ptr_d = 5'd0;
      count_d  = 6'd0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + 5'd1;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + 5'd1;
      if (push_acc && !pop_acc)      count_d = count_q + 6'd1;
      else if (pop_acc && !push_acc) count_d = count_q - 6'd1;
      overflow_d  = overflow_q | (push & full_q & ~pop_acc);
      underflow_d = underflow_q | (pop & empty_q);
    end

    empty_d        = (count_d == 6'd0);
    full_d         = (count_d == DEPTH);
    almost_empty_d = (count_d <= AE_LVL);
    almost_full_d  = (count_d >= AF_LVL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q       <= 5'd0;
      rd_ptr_q       <= 5'd0;
      count_q        <= 6'd0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
      pop_valid_q    <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      empty_q        <= empty_d;
      full_q         <= full_d;
      almost_empty_q <= almost_empty_d;
      almost_full_q  <= almost_full_d;
      pop_valid_q    <= pop_valid_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  assign ram_we       = push_acc;
  assign ram_a        = wr_ptr_q;
  assign ram_di       = push_data;
  assign ram_dpra     = rd_ptr_q;
  // RAM output register already aligns with pop_valid_q; no local data flop.
  assign pop_data     = ram_dpo;
  assign pop_valid    = pop_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural 32x4 registered-read RAM and
// a reference FIFO model feeding a queue of expected pop data.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, clr, push, pop;
  logic [3:0] push_data;
  logic [3:0] pop_data;
  logic       pop_valid, full, empty, almost_full, almost_empty;
  logic [5:0] count;
  logic       overflow, underflow, ram_we;
  logic [4:0] ram_a, ram_dpra;
  logic [3:0] ram_di, ram_dpo;

  logic [3:0] mem [32];

  int n_chk = 0;
  int n_bad = 0;

  logic [3:0] m_fifo [$];
  logic [3:0] exp_q  [$];
  int         m_cnt;
  logic [4:0] m_wr, m_rd;
  logic       m_pv, m_ovf, m_unf;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.AF_LEVEL(28), .AE_LEVEL(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .push(push), .push_data(push_data),
    .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow), .ram_we(ram_we),
    .ram_a(ram_a), .ram_di(ram_di), .ram_dpra(ram_dpra), .ram_dpo(ram_dpo)
  );

  // Registered read, read-before-write on address collision.
  always @(posedge clk) begin
    ram_dpo <= mem[ram_dpra];
    if (ram_we) mem[ram_a] <= ram_di;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check combinational RAM port, update model, check registered outputs.
  task automatic step(input logic p, input logic [3:0] d, input logic po,
                      input logic c, input logic r);
    logic mpa, mpu;
    push = p; push_data = d; pop = po; clr = c; rst_n = r;
    mpa = po & r & ~c & (m_cnt != 0);
    mpu = p & r & ~c & ((m_cnt != 32) | mpa);
    #1;
    chk("ram_we", ram_we, mpu);
    if (mpu) begin
      chk("ram_a", ram_a, m_wr);
      chk("ram_di", ram_di, d);
    end
    if (r && !c) chk("ram_dpra", ram_dpra, m_rd);
    @(posedge clk);
    if (!r) begin
      m_fifo.delete(); m_cnt = 0; m_wr = 0; m_rd = 0; m_pv = 0; m_ovf = 0; m_unf = 0;
    end else if (c) begin
      m_fifo.delete(); m_cnt = 0; m_wr = 0; m_rd = 0; m_pv = 0;
    end else begin
      if (p && m_cnt == 32 && !mpa) m_ovf = 1;
      if (po && m_cnt == 0) m_unf = 1;
      if (mpa) begin
        exp_q.push_back(m_fifo.pop_front());
        m_rd = m_rd + 5'd1;
      end
      if (mpu) begin
        m_fifo.push_back(d);
        m_wr = m_wr + 5'd1;
      end
      m_cnt = m_fifo.size();
      m_pv = mpa;
    end
    @(negedge clk);
    chk("count", count, m_cnt);
    chk("empty", empty, m_cnt == 0);
    chk("full", full, m_cnt == 32);
    chk("almost_full", almost_full, m_cnt >= 28);
    chk("almost_empty", almost_empty, m_cnt <= 4);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
    chk("pop_valid", pop_valid, m_pv);
    if (pop_valid && exp_q.size() > 0) chk("pop_data", pop_data, exp_q.pop_front());
    else if (m_pv) exp_q.delete();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'd0, 0, 0, 1);
  endtask

  task automatic do_reset();
    step(1, 4'hF, 1, 0, 0);
    step(1, 4'hE, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 4'd0;
    m_cnt = 0; m_wr = 0; m_rd = 0; m_pv = 0; m_ovf = 0; m_unf = 0;
    push = 0; pop = 0; clr = 0; rst_n = 0; push_data = 0;

    do_reset();

    // Basic ordering
    step(1, 4'd1, 0, 0, 1);
    step(1, 4'd2, 0, 0, 1);
    step(1, 4'd3, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 4'd0, 1, 0, 1);
    idle(1);
    chk("basic_drained", exp_q.size(), 0);

    // Fill to full, then overflow attempt
    for (int i = 0; i < 32; i++) step(1, 4'(i % 16), 0, 0, 1);
    step(1, 4'h9, 0, 0, 1);
    chk("full_cnt", count, 32);

    // Push+pop at full: oldest out, new entry goes to the tail
    step(1, 4'hA, 1, 0, 1);
    for (int i = 0; i < 32; i++) step(0, 4'd0, 1, 0, 1);
    idle(1);
    chk("full_drained", exp_q.size(), 0);

    // Push+pop while empty: pop rejected
    do_reset();
    step(1, 4'd5, 1, 0, 1);
    step(0, 4'd0, 1, 0, 1);
    idle(1);

    // Wrap test at count=1
    do_reset();
    step(1, 4'd7, 0, 0, 1);
    for (int i = 0; i < 40; i++) step(1, 4'($urandom_range(0, 15)), 1, 0, 1);
    step(0, 4'd0, 1, 0, 1);
    idle(1);
    chk("wrap_no_ovf", overflow, 0);
    chk("wrap_no_unf", underflow, 0);

    // Set an error flag, then flush with push asserted
    step(0, 4'd0, 1, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 4'(i + 3), 0, 0, 1);
    step(1, 4'hC, 1, 1, 1);
    step(1, 4'd4, 0, 0, 1);
    step(1, 4'd6, 0, 0, 1);
    step(0, 4'd0, 1, 0, 1);
    step(0, 4'd0, 1, 0, 1);
    idle(1);

    // Reset mid-stream with a pop in flight
    for (int i = 0; i < 5; i++) step(1, 4'(i + 8), 0, 0, 1);
    step(1, 4'h2, 1, 0, 1);
    step(1, 4'h3, 1, 0, 0);
    idle(2);
    chk("post_reset_cnt", count, 0);
    chk("final_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameter: AF_LEVEL, 28, almost_full asserts when count >= AF_LEVEL.
REQ-002 Parameter: AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL.
REQ-003 Single clock domain; reset synchronous, active-low; every state element updates only on rising clk.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 clr  in  1  synchronous flush; empties FIFO without touching RAM contents.
REQ-007 push  in  1  write request.
REQ-008 push_data  in  4  write data.
REQ-009 pop  in  1  read request.
REQ-010 pop_data  out  4  read data, valid only while pop_valid=1.
REQ-011 pop_valid  out  1  registered; pop_data valid this cycle.
REQ-012 full / empty  out  1 each  registered occupancy flags.
REQ-013 almost_full / almost_empty  out  1 each  registered threshold flags.
REQ-014 count  out  6  occupancy, 0..32.
REQ-015 overflow / underflow  out  1 each  sticky error flags.
REQ-016 ram_we  out  1  to 32x4 RAM write enable.
REQ-017 ram_a  out  5  to RAM write address (write pointer).
REQ-018 ram_di  out  4  to RAM write data.
REQ-019 ram_dpra  out  5  to RAM read address (read pointer).
REQ-020 ram_dpo  in  4  from RAM registered read data (one-cycle latency, read-before-write on address collision).

Function
REQ-021 Depth 32 entries x 4 bits; storage is the external RAM; no data storage inside this block.
REQ-022 push_acc = push & rst_n & ~clr & (~full | pop_acc); pop_acc = pop & rst_n & ~clr & ~empty.
REQ-023 ram_we = push_acc (combinational); ram_a = wr_ptr; ram_di = push_data; ram_dpra = rd_ptr.
REQ-024 wr_ptr, rd_ptr: 5-bit; increment by 1 on push_acc / pop_acc respectively; wrap 31 -> 0 naturally.
REQ-025 count: +1 on push_acc only, -1 on pop_acc only, unchanged when both or neither.
REQ-026 empty = (next count == 0), full = (next count == 32), both registered; almost flags likewise from next count.
REQ-027 Read latency 1: pop_acc at edge N -> pop_valid=1 for cycle after edge N+1... precisely: pop_valid registered = pop_acc of previous cycle; pop_data = ram_dpo combinationally.
REQ-028 Pop while empty: rejected even if push same cycle; underflow set to 1, held until reset.
REQ-029 Push while full without simultaneous pop: rejected, no RAM write, overflow set to 1, held until reset.
REQ-030 Push+pop while full: both accepted; RAM read-before-write returns oldest entry; count stays 32.
REQ-031 Push+pop while count=1: both accepted; count stays 1; popped data is the old entry.
REQ-032 Data written at edge N is poppable from edge N+1 (write-to-read turnaround one cycle).
REQ-033 clr: pointers, count -> 0; empty=1, full=0, almost_empty=1, almost_full=0; pop_valid=0 next cycle; sticky flags unchanged; push/pop that cycle ignored, no error flagged.

Reset
REQ-034 rst_n=0 at an edge: wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, pop_valid=0, overflow=0, underflow=0.
REQ-035 While rst_n=0, ram_we=0; RAM contents are not cleared.
REQ-036 Reset mid-operation discards all queued entries; in-flight pop_valid does not appear after reset.

Verification
REQ-037 Reset, push 1,2,3 on consecutive cycles, then pop x3 -> pop_valid 3 cycles, pop_data 1,2,3, empty=1, count=0.
REQ-038 Push 32 values 0..15,0..15 -> full=1, count=32, almost_full set at count 28; 33rd push -> no ram_we, overflow=1.
REQ-039 Full, push A and pop same cycle -> pop_data = first entry written, count=32, next pops preserve order with A last.
REQ-040 Empty, push 5 and pop same cycle -> pop rejected, underflow=1, count=1; next-cycle pop -> pop_data=5.
REQ-041 Wrap: 40 push/pop pairs at count=1 -> pointers wrap past 31, data order intact, no error flags.
REQ-042 count=10, assert clr with push=1 -> count=0, empty=1, no RAM write, overflow/underflow unchanged; rst_n=0 mid-stream -> REQ-034 values next cycle.
